// File: rtl/pattern_pkg.sv
// Shared mode encoding, colour-bar palette and mode validity check for the
// video test-pattern generator.
package pattern_pkg;

    typedef enum logic [2:0] {
        MODE_LEGACY = 3'd0,
        MODE_BARS   = 3'd1,
        MODE_BORDER = 3'd2,
        MODE_CHECK  = 3'd3,
        MODE_SCROLL = 3'd4,
        MODE_SOLID  = 3'd5
    } mode_e;

    localparam int NUM_BARS = 8;

    // {R,G,B} at 8 bits per channel, left to right across the screen.
    localparam logic [23:0] BAR_COLORS [NUM_BARS] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    localparam logic [7:0] GREY_LEVEL = 8'h80;

    function automatic logic is_valid_mode(input logic [2:0] mode);
        return (mode <= 3'd5);
    endfunction

endpackage

// File: rtl/pattern_mode_ctrl.sv
// Frame-synchronous mode control: holds the pending request, swaps it in at
// frame start, counts frames and flags requests for unsupported modes.
module pattern_mode_ctrl #(
    parameter int CORDW        = 10,
    parameter int FCNTW        = 8,
    parameter int DEFAULT_MODE = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CORDW-1:0] cx_i,
    input  logic [CORDW-1:0] cy_i,
    input  logic [2:0]       mode_in_i,
    input  logic             mode_req_i,
    output logic [2:0]       mode_active_o,
    output logic [FCNTW-1:0] frame_cnt_o,
    output logic             mode_err_o
);
    import pattern_pkg::*;

    localparam logic [2:0] DEF_MODE = 3'(DEFAULT_MODE);

    logic             frame_start_s;
    logic             req_ok_s;
    logic [2:0]       pend_mode_q,   pend_mode_d;
    logic             pend_valid_q,  pend_valid_d;
    logic [2:0]       mode_active_q, mode_active_d;
    logic [FCNTW-1:0] frame_cnt_q,   frame_cnt_d;
    logic             mode_err_q,    mode_err_d;

    // Next-state for pending request, active mode, frame counter and error pulse.
    always_comb begin
        frame_start_s = (cx_i == {CORDW{1'b0}}) && (cy_i == {CORDW{1'b0}});
        req_ok_s      = mode_req_i && is_valid_mode(mode_in_i);
        pend_mode_d   = pend_mode_q;
        pend_valid_d  = pend_valid_q;
        mode_active_d = mode_active_q;
        frame_cnt_d   = frame_cnt_q;
        mode_err_d    = mode_req_i && !is_valid_mode(mode_in_i);
        if (frame_start_s) begin
            frame_cnt_d = frame_cnt_q + {{(FCNTW-1){1'b0}}, 1'b1};
            if (pend_valid_q) begin
                mode_active_d = pend_mode_q;
                pend_valid_d  = 1'b0;
            end
        end
        // A request coinciding with frame start is applied at the following frame.
        if (req_ok_s) begin
            pend_mode_d  = mode_in_i;
            pend_valid_d = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_mode_q   <= DEF_MODE;
            pend_valid_q  <= 1'b0;
            mode_active_q <= DEF_MODE;
            frame_cnt_q   <= {FCNTW{1'b0}};
            mode_err_q    <= 1'b0;
        end else begin
            pend_mode_q   <= pend_mode_d;
            pend_valid_q  <= pend_valid_d;
            mode_active_q <= mode_active_d;
            frame_cnt_q   <= frame_cnt_d;
            mode_err_q    <= mode_err_d;
        end
    end

    assign mode_active_o = mode_active_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign mode_err_o    = mode_err_q;

endmodule

// File: rtl/pattern_gen.sv
// Multi-mode video test-pattern generator: two-stage pixel pipeline (geometry
// flags, then colour) driven by the frame counters, with frame-synchronous mode changes.
module pattern_gen #(
    parameter int CORDW        = 10,
    parameter int COLORW       = 8,
    parameter int FCNTW        = 8,
    parameter int BAR_W        = 80,
    parameter int CHECK_SHIFT  = 5,
    parameter int DEFAULT_MODE = 0
) (
    input  logic                clk_pix,
    input  logic                rst_in,
    input  logic [CORDW-1:0]    cx,
    input  logic [CORDW-1:0]    cy,
    input  logic [CORDW-1:0]    screen_start_x,
    input  logic [CORDW-1:0]    screen_start_y,
    input  logic [CORDW-1:0]    frame_width,
    input  logic [CORDW-1:0]    frame_height,
    input  logic [2:0]          mode_in,
    input  logic                mode_req,
    output logic [3*COLORW-1:0] rgb,
    output logic [2:0]          mode_active,
    output logic [FCNTW-1:0]    frame_cnt,
    output logic                mode_err
);
    import pattern_pkg::*;

    localparam logic [CORDW-1:0] ZERO     = {CORDW{1'b0}};
    localparam logic [CORDW-1:0] ONE      = {{(CORDW-1){1'b0}}, 1'b1};
    localparam logic [CORDW-1:0] BAR_LAST = CORDW'(BAR_W - 1);

    function automatic logic [COLORW-1:0] widen(input logic [7:0] c8);
        return COLORW'(c8) << (COLORW - 8);
    endfunction

    pattern_mode_ctrl #(
        .CORDW        (CORDW),
        .FCNTW        (FCNTW),
        .DEFAULT_MODE (DEFAULT_MODE)
    ) u_mode_ctrl (
        .clk_i         (clk_pix),
        .rst_i         (rst_in),
        .cx_i          (cx),
        .cy_i          (cy),
        .mode_in_i     (mode_in),
        .mode_req_i    (mode_req),
        .mode_active_o (mode_active),
        .frame_cnt_o   (frame_cnt),
        .mode_err_o    (mode_err)
    );

    logic [CORDW-1:0] rx_s, ry_s;
    logic             vis_q,  vis_d;
    logic [7:0]       rx_q,   ry_q;
    logic             chk_q,  chk_d;
    logic             left_q, left_d;
    logic             top_q,  top_d;
    logic             edge_q, edge_d;
    logic [CORDW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]       bar_idx_q, bar_idx_d;

    // Stage-1 inputs: screen-relative position, edge flags and bar position.
    always_comb begin
        rx_s   = cx - screen_start_x;
        ry_s   = cy - screen_start_y;
        vis_d  = (cx >= screen_start_x) && (cy >= screen_start_y);
        chk_d  = rx_s[CHECK_SHIFT] ^ ry_s[CHECK_SHIFT];
        left_d = (rx_s == ZERO);
        top_d  = (ry_s == ZERO);
        edge_d = (cx == frame_width - ONE) || (cy == frame_height - ONE);
        // bar_cnt/bar_idx describe the pixel being registered; they count
        // along the line instead of dividing rx by BAR_W.
        if (cx == screen_start_x) begin
            bar_cnt_d = ZERO;
            bar_idx_d = 3'd0;
        end else if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = ZERO;
            bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
        end else begin
            bar_cnt_d = bar_cnt_q + ONE;
            bar_idx_d = bar_idx_q;
        end
    end

    // Stage-1 pipeline registers.
    always_ff @(posedge clk_pix or posedge rst_in) begin
        if (rst_in) begin
            vis_q     <= 1'b0;
            rx_q      <= 8'd0;
            ry_q      <= 8'd0;
            chk_q     <= 1'b0;
            left_q    <= 1'b0;
            top_q     <= 1'b0;
            edge_q    <= 1'b0;
            bar_cnt_q <= ZERO;
            bar_idx_q <= 3'd0;
        end else begin
            vis_q     <= vis_d;
            rx_q      <= rx_s[7:0];
            ry_q      <= ry_s[7:0];
            chk_q     <= chk_d;
            left_q    <= left_d;
            top_q     <= top_d;
            edge_q    <= edge_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    logic [7:0]          r8_s, g8_s, b8_s, fc8_s, scroll_s;
    logic [3*COLORW-1:0] rgb_q, rgb_d;

    // Stage-2 colour selection; mode_active already reflects any frame-start swap.
    always_comb begin
        r8_s     = 8'd0;
        g8_s     = 8'd0;
        b8_s     = 8'd0;
        fc8_s    = 8'(frame_cnt);
        scroll_s = rx_q + fc8_s;
        case (mode_e'(mode_active))
            MODE_LEGACY: begin
                r8_s = {rx_q[5:0] & {6{ry_q[4:3] == ~rx_q[4:3]}}, 2'b00};
                g8_s = rx_q & {8{ry_q[6]}};
                b8_s = ry_q;
            end
            MODE_BARS:   {r8_s, g8_s, b8_s} = BAR_COLORS[bar_idx_q];
            MODE_BORDER: begin
                r8_s = {8{left_q}};
                g8_s = {8{top_q}};
                b8_s = {8{edge_q}};
            end
            MODE_CHECK:  {r8_s, g8_s, b8_s} = {24{chk_q}};
            MODE_SCROLL: begin
                r8_s = scroll_s;
                g8_s = ry_q;
                b8_s = ~scroll_s;
            end
            MODE_SOLID:  {r8_s, g8_s, b8_s} = {GREY_LEVEL, GREY_LEVEL, GREY_LEVEL};
            default:     {r8_s, g8_s, b8_s} = 24'h000000;
        endcase
        if (vis_q) begin
            rgb_d = {widen(r8_s), widen(g8_s), widen(b8_s)};
        end else begin
            rgb_d = {(3*COLORW){1'b0}};
        end
    end

    // Stage-2 output register.
    always_ff @(posedge clk_pix or posedge rst_in) begin
        if (rst_in) begin
            rgb_q <= {(3*COLORW){1'b0}};
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: the stimulus side drives cx/cy frame by
// frame and queues expected outputs; a monitor compares them when they fall due.
`timescale 1ns/1ps
module tb_pattern_gen;
    localparam int CORDW = 10;
    localparam int FCNTW = 8;

    logic             clk_pix = 1'b0;
    logic             rst_in  = 1'b1;
    logic [CORDW-1:0] cx = 10'd1, cy = 10'd0;
    logic [CORDW-1:0] screen_start_x = 10'd0, screen_start_y = 10'd0;
    logic [CORDW-1:0] frame_width = 10'd8, frame_height = 10'd8;
    logic [2:0]       mode_in = 3'd0;
    logic             mode_req = 1'b0;
    logic [23:0]      rgb;
    logic [2:0]       mode_active;
    logic [FCNTW-1:0] frame_cnt;
    logic             mode_err;

    always #5 clk_pix = ~clk_pix;

    pattern_gen #(
        .CORDW(CORDW), .COLORW(8), .FCNTW(FCNTW), .BAR_W(80),
        .CHECK_SHIFT(5), .DEFAULT_MODE(0)
    ) dut (
        .clk_pix(clk_pix), .rst_in(rst_in), .cx(cx), .cy(cy),
        .screen_start_x(screen_start_x), .screen_start_y(screen_start_y),
        .frame_width(frame_width), .frame_height(frame_height),
        .mode_in(mode_in), .mode_req(mode_req), .rgb(rgb),
        .mode_active(mode_active), .frame_cnt(frame_cnt), .mode_err(mode_err)
    );

    typedef struct { int due; logic [23:0] pix; } rgb_exp_t;
    typedef struct { int due; logic [2:0] mode; logic [7:0] fcnt; logic err; } st_exp_t;
    typedef struct { int x; int y; logic [2:0] m; } req_t;

    rgb_exp_t rgb_q[$];
    st_exp_t  st_q[$];
    req_t     reqs[$];

    int edge_n = 0;
    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int         g_w, g_h, g_sx, g_sy;
    logic [2:0] m_act    = 3'd0;
    logic [2:0] m_pend   = 3'd0;
    logic       m_pend_v = 1'b0;
    logic [7:0] m_fcnt   = 8'd0;

    always @(posedge clk_pix) edge_n <= edge_n + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected < 2ms", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] bar_color(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] exp_rgb(input int x, input int y, input logic [2:0] mode,
                                            input logic [7:0] fc);
        logic [9:0] rx, ry;
        logic [7:0] r, g, b;
        int idx;
        if (x < g_sx || y < g_sy) return 24'h000000;
        rx = 10'(x - g_sx);
        ry = 10'(y - g_sy);
        r = 8'd0; g = 8'd0; b = 8'd0;
        case (mode)
            3'd0: begin
                if (ry[4:3] == (2'b11 ^ rx[4:3])) r = {rx[5:0], 2'b00};
                if (ry[6]) g = rx[7:0];
                b = ry[7:0];
            end
            3'd1: begin
                idx = (x - g_sx) / 80;
                if (idx > 7) idx = 7;
                return bar_color(idx);
            end
            3'd2: begin
                if (x == g_sx) r = 8'hFF;
                if (y == g_sy) g = 8'hFF;
                if (x == g_w - 1 || y == g_h - 1) b = 8'hFF;
            end
            3'd3: return (rx[5] != ry[5]) ? 24'hFFFFFF : 24'h000000;
            3'd4: begin
                r = rx[7:0] + fc;
                g = ry[7:0];
                b = 8'hFF - r;
            end
            3'd5: return 24'h808080;
            default: return 24'h000000;
        endcase
        return {r, g, b};
    endfunction

    // Drive one pixel, advance the model and queue what the DUT must show.
    task automatic drive(input int x, input int y);
        logic       rq, e;
        logic [2:0] rm;
        rq = 1'b0; rm = 3'd0;
        foreach (reqs[i]) if (reqs[i].x == x && reqs[i].y == y) begin rq = 1'b1; rm = reqs[i].m; end
        @(posedge clk_pix); #2;
        cx = CORDW'(x); cy = CORDW'(y); mode_req = rq; mode_in = rm;
        if (x == 0 && y == 0) begin
            if (m_pend_v) begin m_act = m_pend; m_pend_v = 1'b0; end
            m_fcnt = m_fcnt + 8'd1;
        end
        e = rq && (rm > 3'd5);
        if (rq && rm <= 3'd5) begin m_pend = rm; m_pend_v = 1'b1; end
        st_q.push_back('{due: edge_n + 1, mode: m_act, fcnt: m_fcnt, err: e});
        rgb_q.push_back('{due: edge_n + 2, pix: exp_rgb(x, y, m_act, m_fcnt)});
    endtask

    task automatic set_geom(input int w, input int h, input int sx, input int sy);
        @(posedge clk_pix); #2;
        mode_req = 1'b0;
        g_w = w; g_h = h; g_sx = sx; g_sy = sy;
        frame_width = CORDW'(w); frame_height = CORDW'(h);
        screen_start_x = CORDW'(sx); screen_start_y = CORDW'(sy);
    endtask

    task automatic run_frame(input int limit);
        int n;
        n = 0;
        for (int y = 0; y < g_h; y++)
            for (int x = 0; x < g_w; x++)
                if (n < limit) begin drive(x, y); n++; end
        reqs.delete();
    endtask

    // Monitor: compare every expectation on the cycle it falls due.
    initial begin : monitor
        st_exp_t  se;
        rgb_exp_t re;
        forever begin
            @(negedge clk_pix);
            while (st_q.size() > 0 && st_q[0].due <= edge_n) begin
                se = st_q.pop_front();
                check("mode_active", 32'(mode_active), 32'(se.mode));
                check("frame_cnt", 32'(frame_cnt), 32'(se.fcnt));
                check("mode_err", 32'(mode_err), 32'(se.err));
            end
            while (rgb_q.size() > 0 && rgb_q[0].due <= edge_n) begin
                re = rgb_q.pop_front();
                check("rgb", 32'(rgb), 32'(re.pix));
            end
        end
    end

    initial begin : stimulus
        repeat (3) @(posedge clk_pix);
        #2;
        check("reset_rgb", 32'(rgb), 32'h0);
        check("reset_mode_active", 32'(mode_active), 32'h0);
        check("reset_frame_cnt", 32'(frame_cnt), 32'h0);
        check("reset_mode_err", 32'(mode_err), 32'h0);
        rst_in = 1'b0;

        // legacy frame; ask for colour bars mid-frame
        set_geom(280, 72, 16, 4);
        reqs.push_back('{x: 100, y: 50, m: 3'd1});
        run_frame(1 << 30);

        // colour bars; ask for checkerboard at cx=400
        set_geom(800, 3, 160, 1);
        reqs.push_back('{x: 400, y: 2, m: 3'd3});
        run_frame(1 << 30);

        // checkerboard; valid border request, then an invalid one
        set_geom(96, 80, 8, 8);
        reqs.push_back('{x: 10, y: 10, m: 3'd2});
        reqs.push_back('{x: 50, y: 40, m: 3'd6});
        run_frame(1 << 30);

        // border; request on the frame-start cycle, then two more (last wins)
        set_geom(40, 12, 4, 2);
        reqs.push_back('{x: 0, y: 0, m: 3'd4});
        reqs.push_back('{x: 10, y: 5, m: 3'd5});
        reqs.push_back('{x: 20, y: 7, m: 3'd4});
        run_frame(1 << 30);

        // scrolling gradient over 257 small frames so frame_cnt wraps
        set_geom(8, 3, 2, 1);
        for (int f = 0; f < 257; f++) begin
            if (f == 256) reqs.push_back('{x: 3, y: 1, m: 3'd5});
            run_frame(1 << 30);
        end

        // solid grey, interrupted by reset mid-frame
        set_geom(40, 12, 4, 2);
        run_frame(206);
        repeat (2) @(posedge clk_pix);
        @(negedge clk_pix); #1;
        check("pre_reset_rgb", 32'(rgb), 32'h808080);
        rst_in = 1'b1;
        #1;
        check("async_reset_rgb", 32'(rgb), 32'h0);
        check("async_reset_frame_cnt", 32'(frame_cnt), 32'h0);
        check("async_reset_mode_active", 32'(mode_active), 32'h0);
        check("async_reset_mode_err", 32'(mode_err), 32'h0);
        st_q.delete();
        rgb_q.delete();
        cx = 10'd1; cy = 10'd0; mode_req = 1'b0;
        repeat (2) @(posedge clk_pix);
        #2;
        rst_in = 1'b0;
        m_act = 3'd0; m_pend = 3'd0; m_pend_v = 1'b0; m_fcnt = 8'd0;

        // after release: default (legacy) mode, frame_cnt restarts
        set_geom(40, 12, 4, 2);
        run_frame(1 << 30);

        repeat (3) @(posedge clk_pix);
        @(negedge clk_pix); #1;
        check("scoreboard_drained", 32'(st_q.size() + rgb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
